pc_control: RTL and testbench

//  Program-counter and control-flow unit feeding the fetch side of the WISC cpu core.
//  - Holds the PC and the Z/V/N flag register, and evaluates B/BR conditions.
//  - Produces PC+2 for PCS, and the sticky halt that the top-level hlt port and
//    the cpu testbench sample.
//  - Sits directly upstream of instruction memory: its pc output is the fetch address.
//  - Consumes the same-cycle instruction plus the ALU flag results.

---
 rtl/pc_control_pkg.sv | 39 +++
 rtl/pc_control_branch_cond.sv | 35 +++
 rtl/pc_control.sv | 109 ++++++++++
 tb/tb_pc_control.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_control_pkg.sv
// Shared encodings for the WISC program-counter / control-flow unit:
// opcodes, branch condition codes and flag-register bit positions.
package pc_control_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [2:0] cond_t;

  localparam opcode_t OP_ADD    = 4'h0;
  localparam opcode_t OP_SUB    = 4'h1;
  localparam opcode_t OP_XOR    = 4'h2;
  localparam opcode_t OP_RED    = 4'h3;
  localparam opcode_t OP_SLL    = 4'h4;
  localparam opcode_t OP_SRA    = 4'h5;
  localparam opcode_t OP_ROR    = 4'h6;
  localparam opcode_t OP_PADDSB = 4'h7;
  localparam opcode_t OP_LW     = 4'h8;
  localparam opcode_t OP_SW     = 4'h9;
  localparam opcode_t OP_LLB    = 4'hA;
  localparam opcode_t OP_LHB    = 4'hB;
  localparam opcode_t OP_B      = 4'hC;
  localparam opcode_t OP_BR     = 4'hD;
  localparam opcode_t OP_PCS    = 4'hE;
  localparam opcode_t OP_HLT    = 4'hF;

  localparam cond_t CC_NE  = 3'b000;
  localparam cond_t CC_EQ  = 3'b001;
  localparam cond_t CC_GT  = 3'b010;
  localparam cond_t CC_LT  = 3'b011;
  localparam cond_t CC_GTE = 3'b100;
  localparam cond_t CC_LTE = 3'b101;
  localparam cond_t CC_OVF = 3'b110;
  localparam cond_t CC_UNC = 3'b111;

  // Flag register is laid out {Z, V, N}.
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/pc_control_branch_cond.sv
// Combinational evaluation of a 3-bit branch condition against the
// registered Z/V/N flags.
module branch_cond
  import pc_control_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  // condition decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GTE:  taken = z | (~z & ~n);
      CC_LTE:  taken = n | z;
      CC_OVF:  taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Program counter, flag register and sticky halt for the WISC core; pc is
// the instruction-memory fetch address.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [15:0]     instr,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic [PC_W-1:0] rs_data,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus2,
  output logic            branch_taken,
  output logic            hlt
);

  opcode_t         opcode;
  logic [8:0]      imm9;
  logic            cond_true;
  logic            is_b;
  logic            is_br;
  logic [PC_W-1:0] b_offset;
  logic [PC_W-1:0] b_target;
  logic [PC_W-1:0] pc_next;
  logic [2:0]      flags_q;
  logic [2:0]      flags_d;
  logic            halted_q;
  logic            halted_d;

  assign opcode = opcode_t'(instr[15:12]);
  assign imm9   = instr[8:0];
  assign is_b   = (opcode == OP_B);
  assign is_br  = (opcode == OP_BR);

  branch_cond u_branch_cond (
    .cond  (instr[11:9]),
    .flags (flags_q),
    .taken (cond_true)
  );

  assign branch_taken = (is_b | is_br) & cond_true;
  // A stalled HLT must not assert hlt, otherwise the PC would freeze early.
  assign hlt          = halted_q | ((opcode == OP_HLT) & ~stall);

  assign pc_plus2 = pc + {{(PC_W-2){1'b0}}, 2'd2};
  assign b_offset = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  assign b_target = pc_plus2 + b_offset;

  // next-PC selection, halt has highest priority
  always_comb begin
    pc_next = pc_plus2;
    if (hlt) begin
      pc_next = pc;
    end else if (is_b && cond_true) begin
      pc_next = b_target;
    end else if (is_br && cond_true) begin
      pc_next = rs_data;
    end else begin
      pc_next = pc_plus2;
    end
  end

  // flag update: arithmetic sets all three, logic/shift ops only Z
  always_comb begin
    flags_d = flags_q;
    if (!stall && !hlt) begin
      case (opcode)
        OP_ADD, OP_SUB: begin
          flags_d[FLG_Z] = alu_z;
          flags_d[FLG_V] = alu_v;
          flags_d[FLG_N] = alu_n;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[FLG_Z] = alu_z;
        default:                        flags_d = flags_q;
      endcase
    end else begin
      flags_d = flags_q;
    end
  end

  // halted is sticky; under stall hlt equals halted_q so it simply holds
  always_comb begin
    halted_d = halted_q | hlt;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      flags_q  <= 3'b000;
      halted_q <= 1'b0;
    end else if (!stall) begin
      pc       <= pc_next;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end else begin
      pc       <= pc;
      flags_q  <= flags_q;
      halted_q <= halted_q;
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed scenarios plus randomized
// instruction streams checked against a behavioural model of the PC unit.
module tb_pc_control;

  localparam logic [15:0] NOP = 16'hA000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic [15:0] instr = NOP;
  logic        alu_z = 1'b0;
  logic        alu_v = 1'b0;
  logic        alu_n = 1'b0;
  logic [15:0] rs_data = 16'h0000;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic        hlt;

  int checks = 0;
  int errors = 0;

  // model state
  int m_pc;
  bit m_z, m_v, m_n;
  bit m_halted;

  pc_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .instr        (instr),
    .alu_z        (alu_z),
    .alu_v        (alu_v),
    .alu_n        (alu_n),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .hlt          (hlt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input bit [2:0] c);
    case (c)
      3'd0:    return !m_z;
      3'd1:    return m_z;
      3'd2:    return !m_z && !m_n;
      3'd3:    return m_n;
      3'd4:    return m_z || (!m_z && !m_n);
      3'd5:    return m_n || m_z;
      3'd6:    return m_v;
      default: return 1'b1;
    endcase
  endfunction

  // Asynchronous reset applied between clock edges; checked before any edge.
  task automatic do_reset();
    instr = NOP;
    stall = 1'b0;
    rst_n = 1'b0;
    #2;
    m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halted = 0;
    check("reset_pc", {16'h0, pc}, 32'h0);
    check("reset_hlt", {31'h0, hlt}, 32'h0);
    check("reset_bt", {31'h0, branch_taken}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One cycle: drive, check combinational outputs vs model, advance model.
  task automatic step(input logic [15:0] i, input bit z, input bit v, input bit n,
                      input logic [15:0] rs, input bit st);
    int op;
    int imm;
    bit bt;
    bit eh;
    int nxt;
    instr = i; alu_z = z; alu_v = v; alu_n = n; rs_data = rs; stall = st;
    @(negedge clk);
    op = int'(i[15:12]);
    bt = (op == 12 || op == 13) && cond_ok(i[11:9]);
    eh = m_halted || (op == 15 && !st);
    check("pc", {16'h0, pc}, m_pc);
    check("pc_plus2", {16'h0, pc_plus2}, (m_pc + 2) & 'hFFFF);
    check("branch_taken", {31'h0, branch_taken}, {31'h0, bt});
    check("hlt", {31'h0, hlt}, {31'h0, eh});
    if (!st) begin
      if (eh) begin
        m_halted = 1;
      end else begin
        imm = int'(i[8:0]);
        if (imm >= 256) imm -= 512;
        if (op == 12 && bt) nxt = m_pc + 2 + 2 * imm;
        else if (op == 13 && bt) nxt = int'(rs);
        else nxt = m_pc + 2;
        m_pc = nxt & 'hFFFF;
        if (op == 0 || op == 1) begin
          m_z = z; m_v = v; m_n = n;
        end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
          m_z = z;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic nops_to(input int target);
    for (int k = 0; k < 64 && m_pc != target; k++) step(NOP, 0, 0, 0, 16'h0, 0);
    check("reach_pc", {16'h0, pc}, target);
  endtask

  initial begin
    #1;
    do_reset();

    // 1. sequential fetch and async reset mid-run
    step(NOP, 0, 0, 0, 16'h0, 0);
    check("seq_pc2", {16'h0, pc}, 32'h2);
    step(NOP, 0, 0, 0, 16'h0, 0);
    check("seq_pc4", {16'h0, pc}, 32'h4);
    step(NOP, 0, 0, 0, 16'h0, 0);
    do_reset();

    // 2. ADD sets Z, then B EQ at 0x0010
    nops_to(16'h000E);
    step(16'h0000, 1, 0, 0, 16'h0, 0);
    step(16'hC204, 0, 0, 0, 16'h0, 0);
    check("b_eq_taken", {16'h0, pc}, 32'h001A);
    do_reset();
    nops_to(16'h000E);
    step(16'h0000, 0, 0, 0, 16'h0, 0);
    step(16'hC204, 0, 0, 0, 16'h0, 0);
    check("b_eq_not_taken", {16'h0, pc}, 32'h0012);

    // 3. flag masking: ZVN=011 then XOR z=1 -> 111
    step(16'h0000, 0, 1, 1, 16'h0, 0);
    step(16'h2000, 1, 0, 0, 16'h0, 0);
    step(16'hCC00, 0, 0, 0, 16'h0, 0);
    step(16'hC600, 0, 0, 0, 16'h0, 0);
    check("flags_z_masked", {29'h0, m_z, m_v, m_n}, 32'h7);

    // 4. negative offset to self and wrap at 0xFFFE
    do_reset();
    step(16'hCFFF, 0, 0, 0, 16'h0, 0);
    check("b_self", {16'h0, pc}, 32'h0);
    step(16'hDE00, 0, 0, 0, 16'hFFFE, 0);
    check("br_fffe", {16'h0, pc}, 32'hFFFE);
    step(NOP, 0, 0, 0, 16'h0, 0);
    check("wrap", {16'h0, pc}, 32'h0);

    // 5. BR unconditional, BR NE not taken
    step(16'hDE00, 0, 0, 0, 16'h1234, 0);
    check("br_unc", {16'h0, pc}, 32'h1234);
    step(16'h0000, 1, 0, 0, 16'h0, 0);
    step(16'hD000, 0, 0, 0, 16'h5555, 0);
    check("br_ne_fall", {16'h0, pc}, 32'h1238);

    // randomized stream, HLT excluded so the run keeps going
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [15:0] ri;
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF) ri[15:12] = 4'hD;
      step(ri, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 4) == 0));
    end

    // 6. HLT under stall, then release; halted state is sticky
    step(16'hF000, 0, 0, 0, 16'h0, 1);
    step(16'hF000, 0, 0, 0, 16'h0, 1);
    step(16'hF000, 0, 0, 0, 16'h0, 0);
    for (int k = 0; k < 6; k++)
      step(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
    step(16'h0000, 1, 1, 1, 16'h0, 0);
    step(16'hCE10, 0, 0, 0, 16'h0, 0);
    check("halted_model", {31'h0, m_halted}, 32'h1);
    do_reset();
    step(NOP, 0, 0, 0, 16'h0, 0);
    check("hlt_cleared_pc", {16'h0, pc}, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
